// File: rtl/fpga_top_pkg.sv
// rtl/fpga_top_pkg.sv - shared types and constants for the bring-up top
package fpga_top_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO   = 2'b00,
        MODE_COUNT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_EDGES  = 2'b11
    } mode_e;

    localparam int           PIN_WIDTH        = 8;
    localparam int           DEFAULT_PRESCALE = 100;
    localparam int           DEFAULT_SYNC     = 2;
    localparam logic [7:0]   ROT_RESET        = 8'h01;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - multi-flop synchronizer for asynchronous input pins
module pin_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/fpga_top.sv
// rtl/fpga_top.sv - board top: synchronized pins, three pattern engines, mode-selected registered outputs
module fpga_top
    import fpga_top_pkg::*;
#(
    parameter int PRESCALE    = DEFAULT_PRESCALE,
    parameter int SYNC_STAGES = DEFAULT_SYNC
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] input_pins,
    output logic [7:0] output_pins
);

    logic [7:0]  in_sync;
    logic        in_prev;
    logic [15:0] presc;
    logic        tick;
    logic        edge_seen;
    logic [7:0]  tcnt;
    logic [7:0]  rot;
    logic [7:0]  ecnt;
    logic [7:0]  mux_out;
    mode_e       mode;

    pin_sync #(
        .WIDTH (PIN_WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_pin_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (input_pins),
        .q     (in_sync)
    );

    assign tick      = (presc == 16'(PRESCALE - 1));
    assign edge_seen = in_sync[0] & ~in_prev;
    assign mode      = mode_e'(in_sync[7:6]);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            in_prev <= 1'b0;
        end else begin
            in_prev <= in_sync[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Engines free-run independently of the selected mode.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tcnt <= 8'h00;
            rot  <= ROT_RESET;
        end else if (tick) begin
            tcnt <= tcnt + 8'd1;
            rot  <= rotl8(rot);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ecnt <= 8'h00;
        end else if (edge_seen) begin
            ecnt <= ecnt + 8'd1;
        end
    end

    always_comb begin
        mux_out = in_sync;
        case (mode)
            MODE_ECHO:   mux_out = in_sync;
            MODE_COUNT:  mux_out = tcnt;
            MODE_ROTATE: mux_out = rot;
            MODE_EDGES:  mux_out = ecnt;
            default:     mux_out = in_sync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            output_pins <= 8'h00;
        end else begin
            output_pins <= mux_out;
        end
    end

endmodule

// File: tb/tb_fpga_top.sv
// tb/tb_fpga_top.sv - directed self-checking bench for fpga_top
module tb_fpga_top;

    logic       clk;
    logic       n_rst;
    logic [7:0] input_pins;
    logic [7:0] output_pins;

    int checks;
    int passed;

    fpga_top #(
        .PRESCALE    (100),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .input_pins  (input_pins),
        .output_pins (output_pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset for a few edges with the given pins, then releases on a falling edge.
    task automatic do_reset(input logic [7:0] pins);
        n_rst      = 1'b0;
        input_pins = pins;
        step(3);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst      = 1'b0;
        input_pins = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (output_pins !== 8'h00)
                $display("FAIL reset_hold[%0d]: got %h expected 00", i, output_pins);
            else
                passed++;
        end
        n_rst = 1'b1;
        step(1);
        checks++;
        if (output_pins !== 8'h00)
            $display("FAIL reset_release: got %h expected 00", output_pins);
        else
            passed++;
    endtask

    task automatic test_echo();
        do_reset(8'h00);
        step(4);
        input_pins = 8'h2A;
        for (int i = 1; i <= 3; i++) begin
            logic [7:0] exp;
            step(1);
            exp = (i < 3) ? 8'h00 : 8'h2A;
            checks++;
            if (output_pins !== exp)
                $display("FAIL echo_2a[%0d]: got %h expected %h", i, output_pins, exp);
            else
                passed++;
        end
        input_pins = 8'h15;
        for (int i = 1; i <= 3; i++) begin
            logic [7:0] exp;
            step(1);
            exp = (i < 3) ? 8'h2A : 8'h15;
            checks++;
            if (output_pins !== exp)
                $display("FAIL echo_15[%0d]: got %h expected %h", i, output_pins, exp);
            else
                passed++;
        end
    endtask

    // tcnt becomes k on edge 100*k after release; the output register shows it one edge later.
    task automatic test_count();
        do_reset(8'h40);
        step(100);
        checks++;
        if (output_pins !== 8'h00) $display("FAIL count_e100: got %h expected 00", output_pins);
        else passed++;
        step(1);
        checks++;
        if (output_pins !== 8'h01) $display("FAIL count_e101: got %h expected 01", output_pins);
        else passed++;
        step(99);
        checks++;
        if (output_pins !== 8'h01) $display("FAIL count_e200: got %h expected 01", output_pins);
        else passed++;
        step(1);
        checks++;
        if (output_pins !== 8'h02) $display("FAIL count_e201: got %h expected 02", output_pins);
        else passed++;
        step(25600 - 201);
        checks++;
        if (output_pins !== 8'hFF) $display("FAIL count_e25600: got %h expected ff", output_pins);
        else passed++;
        step(1);
        checks++;
        if (output_pins !== 8'h00) $display("FAIL count_wrap: got %h expected 00", output_pins);
        else passed++;
    endtask

    task automatic test_rotate();
        logic [7:0] exp;
        do_reset(8'h80);
        step(100);
        checks++;
        if (output_pins !== 8'h01) $display("FAIL rot_before_tick: got %h expected 01", output_pins);
        else passed++;
        exp = 8'h02;
        step(1);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (output_pins !== exp)
                $display("FAIL rot_tick[%0d]: got %h expected %h", k, output_pins, exp);
            else
                passed++;
            exp = (exp == 8'h80) ? 8'h01 : (exp << 1);
            if (k < 9) step(100);
        end
    endtask

    task automatic test_edges();
        do_reset(8'hC0);
        step(3);
        for (int i = 0; i < 5; i++) begin
            input_pins = 8'hC1;
            step(3);
            input_pins = 8'hC0;
            step(3);
        end
        step(2);
        checks++;
        if (output_pins !== 8'h05) $display("FAIL edges_five: got %h expected 05", output_pins);
        else passed++;
        input_pins = 8'h01;
        step(3);
        checks++;
        if (output_pins !== 8'h01) $display("FAIL edges_echo_hi: got %h expected 01", output_pins);
        else passed++;
        input_pins = 8'h00;
        step(3);
        checks++;
        if (output_pins !== 8'h00) $display("FAIL edges_echo_lo: got %h expected 00", output_pins);
        else passed++;
        input_pins = 8'h01;
        step(3);
        input_pins = 8'h00;
        step(3);
        input_pins = 8'hC0;
        step(3);
        checks++;
        if (output_pins !== 8'h07) $display("FAIL edges_after_echo: got %h expected 07", output_pins);
        else passed++;
    endtask

    task automatic test_midrun_reset();
        do_reset(8'h40);
        step(701);
        checks++;
        if (output_pins !== 8'h07) $display("FAIL midrun_pre: got %h expected 07", output_pins);
        else passed++;
        n_rst = 1'b0;
        step(1);
        n_rst = 1'b1;
        checks++;
        if (output_pins !== 8'h00) $display("FAIL midrun_reset: got %h expected 00", output_pins);
        else passed++;
        step(100);
        checks++;
        if (output_pins !== 8'h00) $display("FAIL midrun_e100: got %h expected 00", output_pins);
        else passed++;
        step(1);
        checks++;
        if (output_pins !== 8'h01) $display("FAIL midrun_e101: got %h expected 01", output_pins);
        else passed++;
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        n_rst      = 1'b0;
        input_pins = 8'h00;
        step(1);
        test_reset();
        test_echo();
        test_count();
        test_rotate();
        test_edges();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
